axi_uart_lite_sim: RTL

- Parametrised, cycle-accurate AXI4-Lite UART-Lite-compatible model for the simulation top. It replaces the fixed behavioural UART and sits on the core's AXI4-Lite UART port.
- Adds configurable TX/RX FIFO depths and a configurable TX drain rate.
- Adds a bench-side RX byte injection port and an edge-pulse interrupt matching UART Lite semantics.

---
 rtl/axi_uart_lite_sim_pkg.sv | 36 +++
 rtl/uart_sim_fifo.sv | 52 +++++
 rtl/axi_uart_lite_sim.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_uart_lite_sim_pkg.sv
// Register map, bit positions, response code and status layout shared by the
// axi_uart_lite_sim model and its FIFO sub-module.
package axi_uart_lite_sim_pkg;

    localparam logic [1:0] REG_RXFIFO = 2'd0;
    localparam logic [1:0] REG_TXFIFO = 2'd1;
    localparam logic [1:0] REG_STAT   = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int STAT_RX_VALID = 0;
    localparam int STAT_RX_FULL  = 1;
    localparam int STAT_TX_EMPTY = 2;
    localparam int STAT_TX_FULL  = 3;
    localparam int STAT_IRQ_EN   = 4;
    localparam int STAT_OVERRUN  = 5;

    localparam int CTRL_RST_TX = 0;
    localparam int CTRL_RST_RX = 1;
    localparam int CTRL_IRQ_EN = 4;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Field order matches the STAT bit positions above (rx_valid is bit 0).
    typedef struct packed {
        logic overrun;
        logic irq_en;
        logic tx_full;
        logic tx_empty;
        logic rx_full;
        logic rx_valid;
    } stat_t;

    typedef enum logic {W_IDLE, W_RESP} wr_state_e;
    typedef enum logic {R_IDLE, R_DATA} rd_state_e;

endpackage

// File: rtl/uart_sim_fifo.sv
// Synchronous FIFO with flush. A pop on a full FIFO frees the slot for a
// same-cycle push; flush overrides any same-cycle push or pop.
module uart_sim_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        data_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        data_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: storage has no reset; pointers and count alone define valid entries.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/axi_uart_lite_sim.sv
// AXI4-Lite UART-Lite-compatible simulation model with paced TX drain and RX injection.
// Define UART_SIM_PRINT_EN to echo every transmitted byte to the simulator console.
module axi_uart_lite_sim
    import axi_uart_lite_sim_pkg::*;
#(
    parameter int ADDR_W   = 13,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16,
    parameter int TX_DIV   = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    input  logic [7:0]        rx_byte_i,
    input  logic              rx_valid_i,
    output logic [7:0]        tx_byte_o,
    output logic              tx_strobe_o,
    output logic              uart_irq
);
    localparam int               DIV_W    = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TX_DIV - 1);

    wr_state_e        w_state_q;
    rd_state_e        r_state_q;
    logic             arready_q;
    logic [31:0]      rdata_q;
    logic [31:0]      rdata_d;
    logic             irq_en_q;
    logic             overrun_q;
    logic             irq_q;
    logic             tx_strobe_q;
    logic [7:0]       tx_byte_q;
    logic [DIV_W-1:0] div_cnt_q;
    logic             tx_empty_prev_q;
    logic             rx_empty_prev_q;

    logic       aw_hs, ar_hs;
    logic [1:0] w_idx, r_idx;
    logic       tx_push, tx_pop, tx_flush, tx_full, tx_empty;
    logic       rx_pop, rx_flush, rx_full, rx_empty, rx_overrun;
    logic [7:0] tx_head, rx_head;
    logic [$clog2(TX_DEPTH):0] tx_count_unused;
    logic [$clog2(RX_DEPTH):0] rx_count_unused;
    logic       unused_bits;
    stat_t      stat;

    assign w_idx = s_axi_awaddr[3:2];
    assign r_idx = s_axi_araddr[3:2];
    assign aw_hs = !rst_i && (w_state_q == W_IDLE) && s_axi_awvalid && s_axi_wvalid;
    assign ar_hs = (r_state_q == R_IDLE) && arready_q && s_axi_arvalid;

    assign tx_push    = aw_hs && (w_idx == REG_TXFIFO) && s_axi_wstrb[0];
    assign tx_flush   = aw_hs && (w_idx == REG_CTRL) && s_axi_wdata[CTRL_RST_TX];
    assign rx_flush   = aw_hs && (w_idx == REG_CTRL) && s_axi_wdata[CTRL_RST_RX];
    assign rx_pop     = ar_hs && (r_idx == REG_RXFIFO);
    assign tx_pop     = !tx_empty && (div_cnt_q == DIV_LAST);
    assign rx_overrun = rx_valid_i && rx_full && !rx_pop && !rx_flush;

    uart_sim_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (tx_flush),
        .push_i  (tx_push),
        .data_i  (s_axi_wdata[7:0]),
        .pop_i   (tx_pop),
        .data_o  (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count_unused)
    );

    uart_sim_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (rx_flush),
        .push_i  (rx_valid_i),
        .data_i  (rx_byte_i),
        .pop_i   (rx_pop),
        .data_o  (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count_unused)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        stat          = '0;
        stat.rx_valid = !rx_empty;
        stat.rx_full  = rx_full;
        stat.tx_empty = tx_empty;
        stat.tx_full  = tx_full;
        stat.irq_en   = irq_en_q;
        stat.overrun  = overrun_q;
    end

    always_comb begin
        rdata_d = '0;
        case (r_idx)
            REG_RXFIFO: if (!rx_empty) rdata_d = {24'b0, rx_head};
            REG_STAT:   rdata_d = {26'b0, stat};
            default:    rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state_q <= W_IDLE;
            irq_en_q  <= 1'b0;
        end else begin
            case (w_state_q)
                W_IDLE: if (aw_hs) begin
                    w_state_q <= W_RESP;
                    if (w_idx == REG_CTRL) irq_en_q <= s_axi_wdata[CTRL_IRQ_EN];
                end
                W_RESP: if (s_axi_bready) w_state_q <= W_IDLE;
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: if (ar_hs) begin
                    r_state_q <= R_DATA;
                    arready_q <= 1'b0;
                    rdata_q   <= rdata_d;
                end else begin
                    arready_q <= 1'b1;
                end
                R_DATA: if (s_axi_rready) begin
                    r_state_q <= R_IDLE;
                    arready_q <= 1'b1;
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    // Interrupt edges are found by comparing FIFO emptiness against the previous cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overrun_q       <= 1'b0;
            div_cnt_q       <= '0;
            tx_strobe_q     <= 1'b0;
            tx_byte_q       <= '0;
            irq_q           <= 1'b0;
            tx_empty_prev_q <= 1'b1;
            rx_empty_prev_q <= 1'b1;
        end else begin
            if (rx_overrun) begin
                overrun_q <= 1'b1;
            end else if (ar_hs && (r_idx == REG_STAT)) begin
                overrun_q <= 1'b0;
            end
            if (tx_empty || tx_pop) begin
                div_cnt_q <= '0;
            end else begin
                div_cnt_q <= div_cnt_q + DIV_W'(1);
            end
            tx_strobe_q <= tx_pop && !tx_flush;
            if (tx_pop) tx_byte_q <= tx_head;
            tx_empty_prev_q <= tx_empty;
            rx_empty_prev_q <= rx_empty;
            irq_q <= irq_en_q && ((rx_empty_prev_q && !rx_empty) || (!tx_empty_prev_q && tx_empty));
        end
    end

`ifdef UART_SIM_PRINT_EN
    always_ff @(posedge clk_i) begin
        if (tx_strobe_q) begin
            $write("%c", tx_byte_q);
        end
    end
`else
    // Console echo compiled out; port behaviour is unchanged.
`endif

    assign s_axi_awready = aw_hs;
    assign s_axi_wready  = aw_hs;
    assign s_axi_bvalid  = (w_state_q == W_RESP);
    assign s_axi_bresp   = RESP_OKAY;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = (r_state_q == R_DATA);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = RESP_OKAY;
    assign tx_byte_o     = tx_byte_q;
    assign tx_strobe_o   = tx_strobe_q;
    assign uart_irq      = irq_q;

    assign unused_bits = ^{s_axi_awaddr[ADDR_W-1:4], s_axi_awaddr[1:0],
                           s_axi_araddr[ADDR_W-1:4], s_axi_araddr[1:0],
                           s_axi_wdata[31:8], s_axi_wstrb[3:1],
                           tx_count_unused, rx_count_unused};

endmodule
